// File: rtl/instr_mem_resp.sv
// Instruction memory responder: a program-loadable word array with a configurable
// grant delay, answering each granted fetch one cycle later.
module instr_mem_resp #(
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter int                    GNT_WAIT    = 0,
    parameter logic [WORD_WIDTH-1:0] NOOP_INSTR  = WORD_WIDTH'(32'h00000013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    input  logic [WORD_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  load_we_i,
    input  logic [WORD_WIDTH-1:0] load_addr_i,
    input  logic [WORD_WIDTH-1:0] load_data_i,
    output logic [0:0]            dbg_state,
    output logic [2:0]            dbg_cnt
);

    // Handshake: the fetcher holds instr_req_i/instr_addr_i until instr_gnt_o is
    // seen high in the same cycle; the address is consumed at that edge and
    // instr_rvalid_o pulses for exactly one cycle afterwards with no backpressure.

    localparam int                    AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WORD_WIDTH-1:0] DEPTH_LIMIT = WORD_WIDTH'(DEPTH_WORDS);
    localparam logic [2:0]            GNT_WAIT_C  = 3'(GNT_WAIT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [WORD_WIDTH-1:0] fetch_word;
    logic [WORD_WIDTH-1:0] load_word;
    logic                  fetch_in_range;
    logic                  load_in_range;
    logic [AW-1:0]         fetch_idx;
    logic [AW-1:0]         load_idx;

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [2:0]            cnt_q;
    logic [2:0]            cnt_d;
    logic                  gnt;

    logic                  rvalid_q;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign fetch_word     = instr_addr_i >> 2;
    assign load_word      = load_addr_i >> 2;
    assign fetch_in_range = (fetch_word < DEPTH_LIMIT);
    assign load_in_range  = (load_word < DEPTH_LIMIT);
    assign fetch_idx      = fetch_word[AW-1:0];
    assign load_idx       = load_word[AW-1:0];

    // Array contents are deliberately left out of reset so a loaded program survives it.
    always_ff @(posedge clk) begin
        if (load_we_i && load_in_range) begin
            mem[load_idx] <= load_data_i;
        end
    end

    // A load in progress blocks grants and freezes the wait count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_req_i && !load_we_i) begin
                        if (GNT_WAIT == 0) begin
                            gnt = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = 3'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!instr_req_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end else if (!load_we_i) begin
                        if (cnt_q == GNT_WAIT_C) begin
                            gnt     = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            if (gnt) begin
                rdata_q <= fetch_in_range ? mem[fetch_idx] : NOOP_INSTR;
                err_q   <= !fetch_in_range;
            end
        end
    end

    // Masking with rst drops a response that would land in a reset cycle.
    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid_q && !rst;
    assign instr_rdata_o  = rst ? '0 : rdata_q;
    assign instr_err_o    = err_q && !rst;

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_mem_resp.sv
// Directed bench for instr_mem_resp: three instances (GNT_WAIT 0, 2, 3) share one
// clock and reset; responses are scoreboarded against a bench-side memory model.
module tb_instr_mem_resp;

    localparam int W = 32;
    localparam logic [W-1:0] NOOP = 32'h00000013;

    logic           clk;
    logic           rst;
    logic           req    [3];
    logic [W-1:0]   addr   [3];
    logic           gnt    [3];
    logic           rvalid [3];
    logic [W-1:0]   rdata  [3];
    logic           err    [3];
    logic           we     [3];
    logic [W-1:0]   la     [3];
    logic [W-1:0]   ld     [3];
    logic [0:0]     dbg_st [3];
    logic [2:0]     dbg_cn [3];

    logic [W-1:0]   mdl [3][1024];
    logic [W+2:0]   exp_q[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instr_mem_resp #(
            .WORD_WIDTH (W),
            .DEPTH_WORDS(1024),
            .GNT_WAIT   ((g == 0) ? 0 : g + 1),
            .NOOP_INSTR (NOOP)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .instr_req_i   (req[g]),
            .instr_addr_i  (addr[g]),
            .instr_gnt_o   (gnt[g]),
            .instr_rvalid_o(rvalid[g]),
            .instr_rdata_o (rdata[g]),
            .instr_err_o   (err[g]),
            .load_we_i     (we[g]),
            .load_addr_i   (la[g]),
            .load_data_i   (ld[g]),
            .dbg_state     (dbg_st[g]),
            .dbg_cnt       (dbg_cn[g])
        );
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic load(input int k, input logic [W-1:0] a, input logic [W-1:0] d);
        we[k] = 1'b1;
        la[k] = a;
        ld[k] = d;
        if ((a >> 2) < 1024) mdl[k][(a >> 2) % 1024] = d;
        tick();
        we[k] = 1'b0;
    endtask

    function automatic logic [W+2:0] expect_rsp(input int k, input logic [W-1:0] a);
        logic [W-1:0] wa;
        wa = a >> 2;
        if (wa < 1024) return {2'(k), 1'b0, mdl[k][wa % 1024]};
        return {2'(k), 1'b1, NOOP};
    endfunction

    // Single fetch on the zero-wait instance: grant same cycle, rvalid next.
    task automatic fetch0(input logic [W-1:0] a);
        req[0]  = 1'b1;
        addr[0] = a;
        mid();
        check("gnt_same_cycle", gnt[0], 1'b1);
        exp_q.push_back(expect_rsp(0, a));
        tick();
        req[0] = 1'b0;
        mid();
        check("rvalid_latency1", rvalid[0], 1'b1);
        tick();
    endtask

    // Scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rvalid[k]) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", rvalid[k], 1'b0);
                end else begin
                    logic [W+2:0] e;
                    e = exp_q.pop_front();
                    check("rsp", {2'(k), err[k], rdata[k]}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b1; addr[k] = '0; we[k] = 1'b0; la[k] = '0; ld[k] = '0;
        end
        tick();
        tick();
        mid();
        for (int k = 0; k < 3; k++) begin
            check("reset_gnt_low", gnt[k], 1'b0);
            check("reset_rvalid", rvalid[k], 1'b0);
            check("reset_rdata", rdata[k], '0);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        mid();
        check("post_reset_state", dbg_st[2], 1'b0);
        check("post_reset_err", err[0], 1'b0);
        tick();

        // Basic zero-wait fetch
        load(0, 32'h0, 32'h00500093);
        load(0, 32'h4, 32'h00A00113);
        load(0, 32'h8, 32'h00F00193);
        fetch0(32'h0);

        // Streaming: one grant per cycle, responses in order
        req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr[0] = 32'(i * 4);
            mid();
            check("stream_gnt", gnt[0], 1'b1);
            exp_q.push_back(expect_rsp(0, 32'(i * 4)));
            if (i > 0) check("stream_rvalid", rvalid[0], 1'b1);
            tick();
        end
        req[0] = 1'b0;
        mid();
        check("stream_rvalid", rvalid[0], 1'b1);
        tick();
        mid();
        check("hold_rvalid_low", rvalid[0], 1'b0);
        check("hold_rdata", rdata[0], 32'h00F00193);
        tick();

        // Low address bits ignored, then an out-of-range fetch
        fetch0(32'h6);
        fetch0(32'h1000);
        mid();
        check("hold_err", err[0], 1'b1);
        check("hold_noop", rdata[0], NOOP);
        tick();

        // Reset in the cycle after a grant swallows the response
        req[0]  = 1'b1;
        addr[0] = 32'h0;
        mid();
        check("pre_reset_gnt", gnt[0], 1'b1);
        tick();
        req[0] = 1'b0;
        rst    = 1'b1;
        mid();
        check("reset_drop_rvalid", rvalid[0], 1'b0);
        check("reset_drop_rdata", rdata[0], '0);
        check("reset_drop_err", err[0], 1'b0);
        tick();
        rst = 1'b0;
        mid();
        check("after_reset_rvalid", rvalid[0], 1'b0);
        tick();
        fetch0(32'h0);

        // GNT_WAIT=3: grant only in the fourth cycle of the held request
        load(2, 32'h10, 32'hCAFE0113);
        req[2]  = 1'b1;
        addr[2] = 32'h10;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("wait3_gnt", gnt[2], (i == 3));
            if (i == 1) check("wait3_state", dbg_st[2], 1'b1);
            if (i == 3) exp_q.push_back(expect_rsp(2, 32'h10));
            tick();
        end
        req[2] = 1'b0;
        mid();
        check("wait3_rvalid", rvalid[2], 1'b1);
        tick();

        // GNT_WAIT=2 with a 2-cycle load collision on the fetched word
        load(1, 32'h20, 32'h11111111);
        req[1]  = 1'b1;
        addr[1] = 32'h20;
        for (int i = 0; i < 5; i++) begin
            we[1] = (i == 1 || i == 2);
            la[1] = 32'h20;
            ld[1] = 32'h00A00113;
            if (we[1]) mdl[1][8] = 32'h00A00113;
            mid();
            check("collide_gnt", gnt[1], (i == 4));
            if (i == 2) check("collide_cnt_frozen", dbg_cn[1], 3'd1);
            if (i == 4) exp_q.push_back(expect_rsp(1, 32'h20));
            tick();
        end
        we[1]  = 1'b0;
        req[1] = 1'b0;
        mid();
        check("collide_rvalid", rvalid[1], 1'b1);
        tick();

        // Request dropped while waiting: back to idle, no grant, no response
        req[1] = 1'b1;
        mid();
        check("drop_gnt", gnt[1], 1'b0);
        tick();
        req[1] = 1'b0;
        mid();
        check("drop_gnt", gnt[1], 1'b0);
        tick();
        mid();
        check("drop_state_idle", dbg_st[1], 1'b0);
        check("drop_no_rvalid", rvalid[1], 1'b0);
        tick();

        tick();
        tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
